// File: rtl/delay_line_checker.sv
// delay_line_checker
// Receive-side monitor for a fixed-latency path. It keeps its own STAGES-deep
// history of the source stream and compares the delayed copy against the
// path's output on every cycle while armed. It reports saturating pass/error
// counts and a sticky error flag.
//
// Optional build macro: DELAY_LINE_CHECKER_CAPTURE_EN
//   When defined, err_exp/err_got latch the expected/observed data at the first
//   mismatch after reset or clear. When undefined, both outputs are tied to 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | check_en low or just reset; no compares, fill counter at 0
// FILL  | history refilling after enable; counts samples up to STAGES
// CHECK | comparing dut_data against the history every cycle (armed=1)

module delay_line_checker #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             check_en,
  input  logic [WIDTH-1:0] src_data,
  input  logic [WIDTH-1:0] dut_data,
  output logic             armed,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // The IDLE->FILL edge already captures the first sample, so FILL ends once
  // STAGES samples are in; with 0 or 1 stages the entry edge is enough.
  localparam logic [6:0]       FILL_LAST = 7'(STAGES - 1);
  localparam bit               SKIP_FILL = (STAGES <= 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic [6:0]       fill_cnt;
  logic [WIDTH-1:0] exp_data;
  logic             mismatch;
  logic             do_cmp;

  generate
    if (STAGES > 0) begin : g_hist
      logic [WIDTH-1:0] hist [STAGES];

      // History shift chain runs every cycle, independent of check_en.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < STAGES; i++) hist[i] <= '0;
        end else begin
          hist[0] <= src_data;
          for (int i = 1; i < STAGES; i++) hist[i] <= hist[i-1];
        end
      end

      assign exp_data = hist[STAGES-1];
    end else begin : g_wire
      assign exp_data = src_data;
    end
  endgenerate

  assign mismatch = (dut_data != exp_data);
  assign do_cmp   = (state == CHECK);

  // Sequencing FSM; armed is registered alongside the state it mirrors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else if (!check_en) begin
      state    <= IDLE;
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SKIP_FILL) begin
            state    <= CHECK;
            fill_cnt <= '0;
            armed    <= 1'b1;
          end else begin
            state    <= FILL;
            fill_cnt <= 7'd1;
            armed    <= 1'b0;
          end
        end
        FILL: begin
          if (fill_cnt >= FILL_LAST) begin
            state    <= CHECK;
            fill_cnt <= '0;
            armed    <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 7'd1;
            armed    <= 1'b0;
          end
        end
        CHECK: begin
          armed <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          fill_cnt <= '0;
          armed    <= 1'b0;
        end
      endcase
    end
  end

  // Compare result accounting; clear overrides a compare on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= '0;
      err_cnt  <= '0;
      error    <= 1'b0;
    end else if (clear) begin
      pass_cnt <= '0;
      err_cnt  <= '0;
      error    <= 1'b0;
    end else if (do_cmp) begin
      if (!mismatch) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        error <= 1'b1;
      end
    end
  end

`ifdef DELAY_LINE_CHECKER_CAPTURE_EN
  // First-mismatch capture; the still-clear error flag marks "first".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_exp <= '0;
      err_got <= '0;
    end else if (clear) begin
      err_exp <= '0;
      err_got <= '0;
    end else if (do_cmp && mismatch && !error) begin
      err_exp <= exp_data;
      err_got <= dut_data;
    end
  end
`else
  assign err_exp = '0;
  assign err_got = '0;
`endif

endmodule
